alu_seq_ctrl: RTL

- Sequencing controller for the shared 8-bit ripple-carry add/sub unit in the ALU.
- Accepts one operation per start handshake and drives the adder's x/y/op inputs from internal registers.
- Runs ADD/SUB in one adder pass and unsigned MUL as 8 shift-and-add iterations.
- Returns a registered 16-bit result plus flags.
- Sits between the ALU top-level decoder and the single add/sub datapath instance.

---
 rtl/alu_seq_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences ADD/SUB (one adder pass) and unsigned MUL (8 shift-and-add passes) on the shared 8-bit adder.
// busy while not IDLE, start ignored then (no queueing); defining ALU_SEQ_DIV_EN adds restoring DIV on opcode 11.
module alu_seq_ctrl #(
  parameter int W      = 8,
  parameter int ITER_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     opcode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           ovf,
  output logic           err,
  output logic [W-1:0]   add_x,
  output logic [W-1:0]   add_y,
  output logic           add_op,
  input  logic [W-1:0]   add_z,
  input  logic           add_cout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
`ifdef ALU_SEQ_DIV_EN
    S_DIV  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_sub;
  logic [W-1:0]      r_acc;
  logic [W-1:0]      r_q;
  logic [ITER_W-1:0] r_cnt;
  logic [2*W-1:0]    r_result;
  logic              r_carry;
  logic              r_ovf;
  logic              r_err;

  logic              w_last;
  logic              w_exec_ovf;
  logic [W:0]        w_mul_sum;
  logic [W-1:0]      w_mul_acc;
  logic [W-1:0]      w_mul_q;

  assign w_last     = (r_cnt == ITER_W'(W-1));
  assign w_exec_ovf = (add_z[W-1] != r_a[W-1]) &&
                      (r_sub ? (r_a[W-1] != r_b[W-1]) : (r_a[W-1] == r_b[W-1]));

  // Multiplier bit 0 selects whether this pass adds b; then {carry,acc,q} shifts right one.
  assign w_mul_sum  = r_q[0] ? {add_cout, add_z} : {1'b0, r_acc};
  assign w_mul_acc  = w_mul_sum[W:1];
  assign w_mul_q    = {w_mul_sum[0], r_q[W-1:1]};

`ifdef ALU_SEQ_DIV_EN
  logic              w_div_hi;
  logic [W-1:0]      w_div_rsh;
  logic              w_div_take;
  logic [W-1:0]      w_div_r;
  logic [W-1:0]      w_div_q;

  // hi catches a shifted remainder of 9 bits, which always exceeds the divisor.
  assign w_div_hi   = r_acc[W-1];
  assign w_div_rsh  = {r_acc[W-2:0], r_q[W-1]};
  assign w_div_take = w_div_hi | add_cout;
  assign w_div_r    = w_div_take ? add_z : w_div_rsh;
  assign w_div_q    = {r_q[W-2:0], w_div_take};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    add_x  = '0;
    add_y  = '0;
    add_op = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (opcode)
            2'b00, 2'b01: w_next = S_EXEC;
            2'b10:        w_next = S_MUL;
`ifdef ALU_SEQ_DIV_EN
            default:      w_next = S_DIV;
`else
            default:      w_next = S_DONE;
`endif
          endcase
        end
      end
      S_EXEC: begin
        add_x  = r_a;
        add_y  = r_b;
        add_op = r_sub;
        w_next = S_DONE;
      end
      S_MUL: begin
        add_x = r_acc;
        add_y = r_b;
        if (w_last) w_next = S_DONE;
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        add_x  = w_div_rsh;
        add_y  = r_b;
        add_op = 1'b1;
        if (w_last) w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= opcode[0];
            r_acc <= '0;
            r_q   <= a;
            r_cnt <= '0;
            r_err <= 1'b0;
`ifndef ALU_SEQ_DIV_EN
            if (opcode == 2'b11) begin
              r_result <= '0;
              r_carry  <= 1'b0;
              r_ovf    <= 1'b0;
              r_err    <= 1'b1;
            end
`endif
          end
        end
        S_EXEC: begin
          r_result <= {{W{1'b0}}, add_z};
          r_carry  <= add_cout;
          r_ovf    <= w_exec_ovf;
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_cnt <= r_cnt + ITER_W'(1);
          if (w_last) begin
            r_result <= {w_mul_acc, w_mul_q};
            r_carry  <= 1'b0;
            r_ovf    <= |w_mul_acc;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          r_acc <= w_div_r;
          r_q   <= w_div_q;
          r_cnt <= r_cnt + ITER_W'(1);
          if (w_last) begin
            r_result <= {w_div_r, w_div_q};
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign carry  = r_carry;
  assign ovf    = r_ovf;
  assign err    = r_err;

endmodule
